// File: rtl/countdown_timer_13.sv
// countdown_timer_13
//   Loadable down-counting timer with a programmable prescaler, one-shot or
//   auto-reload operation, a one-cycle terminal-count pulse and a sticky
//   expired flag.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   enable       count qualifier; prescaler and counter hold while low
//   load         single-cycle request: load load_value and start counting
//   load_value   period to load (WIDTH bits)
//   auto_reload  1 = periodic, 0 = one-shot; sampled at each terminal event
//   clr_expired  clears the sticky expired flag (a coincident set wins)
//   out          current count (registered)
//   busy         high while the timer is running
//   tc           terminal-count pulse, one cycle wide (registered)
//   expired      sticky flag, set on every terminal event
module countdown_timer_13 #(
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PS_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             clr_expired,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state, state_d;
  logic [PS_W-1:0]  ps, ps_d;
  logic [WIDTH-1:0] reload, reload_d;
  logic [WIDTH-1:0] out_d;
  logic             tc_d, expired_d, term;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ps      <= '0;
      reload  <= '0;
      out     <= '0;
      tc      <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_d;
      ps      <= ps_d;
      reload  <= reload_d;
      out     <= out_d;
      tc      <= tc_d;
      expired <= expired_d;
    end
  end

  always_comb begin
    state_d  = state;
    ps_d     = ps;
    reload_d = reload;
    out_d    = out;
    term     = 1'b0;

    if (load) begin
      reload_d = load_value;
      out_d    = load_value;
      ps_d     = '0;
      if (load_value != '0) begin
        state_d = RUN;
      end else begin
        // A zero period terminates immediately and never free-runs.
        state_d = IDLE;
        term    = 1'b1;
      end
    end else if (state == RUN && enable) begin
      if (ps != PS_LAST) begin
        ps_d = ps + PS_ONE;
      end else begin
        ps_d = '0;
        if (out > ONE) begin
          out_d = out - ONE;
        end else begin
          // Terminal step: reload in place so periodic mode has no dead cycle.
          term = 1'b1;
          if (auto_reload) begin
            out_d = reload;
          end else begin
            out_d   = '0;
            state_d = IDLE;
          end
        end
      end
    end

    tc_d      = term;
    expired_d = term ? 1'b1 : (clr_expired ? 1'b0 : expired);
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer_13.sv
module tb_countdown_timer_13;

  localparam int unsigned WIDTH = 13;

  logic             clk = 1'b0;
  logic             reset, enable, load, auto_reload, clr_expired;
  logic [WIDTH-1:0] load_value;

  logic [WIDTH-1:0] out1, out4;
  logic             busy1, busy4, tc1, tc4, exp1, exp4;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  countdown_timer_13 #(.WIDTH(WIDTH), .PRESCALE(1), .PS_W(8)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .auto_reload(auto_reload),
    .clr_expired(clr_expired), .out(out1), .busy(busy1), .tc(tc1),
    .expired(exp1)
  );

  countdown_timer_13 #(.WIDTH(WIDTH), .PRESCALE(4), .PS_W(8)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .auto_reload(auto_reload),
    .clr_expired(clr_expired), .out(out4), .busy(busy4), .tc(tc4),
    .expired(exp4)
  );

  always #5 clk = ~clk;

  // Reference model: each timer is tracked as the number of enabled cycles
  // left until its terminal event; the visible count is that figure divided
  // by the prescale, rounded up.
  int unsigned      pre [2] = '{1, 4};
  int unsigned      left[2];
  int unsigned      per [2];
  bit               m_busy[2], m_tc[2], m_exp[2];
  logic [WIDTH-1:0] m_out[2];

  task automatic model_step(input int i);
    bit hit;
    hit = 0;
    if (!reset) begin
      left[i] = 0; per[i] = 0; m_busy[i] = 0; m_out[i] = '0;
      m_tc[i] = 0; m_exp[i] = 0;
    end else begin
      if (load) begin
        per[i] = load_value;
        if (load_value == 0) begin
          hit = 1; m_busy[i] = 0; left[i] = 0; m_out[i] = '0;
        end else begin
          m_busy[i] = 1; left[i] = load_value * pre[i]; m_out[i] = load_value;
        end
      end else if (m_busy[i] && enable) begin
        left[i] = left[i] - 1;
        if (left[i] == 0) begin
          hit = 1;
          if (auto_reload) begin
            left[i] = per[i] * pre[i];
            m_out[i] = WIDTH'(per[i]);
          end else begin
            m_busy[i] = 0;
            m_out[i] = '0;
          end
        end else begin
          m_out[i] = WIDTH'((left[i] + pre[i] - 1) / pre[i]);
        end
      end
      m_tc[i] = hit;
      if (hit) m_exp[i] = 1;
      else if (clr_expired) m_exp[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input int cyc, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  int cycle = 0;

  // One clock: inputs are already stable, model advances on the edge and
  // the DUT outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    cycle++;
    chk("out_p1",  cycle, out1, m_out[0]);
    chk("busy_p1", cycle, WIDTH'(busy1), WIDTH'(m_busy[0]));
    chk("tc_p1",   cycle, WIDTH'(tc1),   WIDTH'(m_tc[0]));
    chk("exp_p1",  cycle, WIDTH'(exp1),  WIDTH'(m_exp[0]));
    chk("out_p4",  cycle, out4, m_out[1]);
    chk("busy_p4", cycle, WIDTH'(busy4), WIDTH'(m_busy[1]));
    chk("tc_p4",   cycle, WIDTH'(tc4),   WIDTH'(m_tc[1]));
    chk("exp_p4",  cycle, WIDTH'(exp4),  WIDTH'(m_exp[1]));
  endtask

  task automatic idle_inputs();
    reset = 1; load = 0; clr_expired = 0;
  endtask

  bit en_pat[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    // Reset held with a coincident load request.
    reset = 0; enable = 1; load = 1; load_value = 100;
    auto_reload = 0; clr_expired = 0;
    tick(); tick();
    idle_inputs();
    tick(); tick();

    // One-shot period 5.
    load = 1; load_value = 5; auto_reload = 0; enable = 1;
    tick();
    load = 0;
    repeat (7) tick();
    clr_expired = 1;
    tick();
    clr_expired = 0;
    repeat (14) tick();

    // Auto-reload period 3 with enable gaps.
    load = 1; load_value = 3; auto_reload = 1; enable = 1;
    tick();
    load = 0;
    for (int i = 0; i < 30; i++) begin
      enable = en_pat[i % 6];
      tick();
    end

    // One-shot period 2 (prescaled instance shows 4 edges per count).
    load = 1; load_value = 2; auto_reload = 0; enable = 1;
    tick();
    load = 0;
    repeat (10) tick();

    // Reload while the count sits at 1 on a decrement edge.
    load = 1; load_value = 2;
    tick();
    load = 0;
    tick();
    load = 1; load_value = 10;
    tick();
    load = 0;
    repeat (3) tick();

    // Zero load while running.
    load = 1; load_value = 0;
    tick();
    load = 0;
    repeat (2) tick();

    // Terminal event coincident with clr_expired.
    load = 1; load_value = 1;
    tick();
    load = 0; clr_expired = 1;
    tick();
    clr_expired = 0;
    repeat (5) tick();

    // Reset in the middle of a maximum-length count.
    load = 1; load_value = 8191; auto_reload = 1;
    tick();
    load = 0;
    repeat (100) tick();
    reset = 0;
    tick();
    reset = 1;
    repeat (10) tick();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 79) != 0);
      load        = ($urandom_range(0, 11) == 0);
      load_value  = WIDTH'($urandom_range(0, 7));
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1) == 1;
      clr_expired = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_13.md
Name: countdown_timer_13

Overview:
Loadable 13-bit down-counting timer with a programmable prescaler, one-shot or auto-reload modes, and a terminal-count pulse. It is the count-down counterpart to the team's free-running up counter. Control logic loads a period, and the timer decrements to zero and signals expiry. It is used for timeouts and periodic tick generation alongside the up-counter blocks.

Parameters:
- WIDTH, 13: counter, load and output width in bits.
- PRESCALE, 1: number of enabled clock cycles per decrement. Legal range is 1..256.
- PS_W, 8: prescaler counter width. Must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  count qualifier. When low, the prescaler and counter hold.
- load  input  1  single-cycle request to load load_value and start counting.
- load_value  input  WIDTH  period to load.
- auto_reload  input  1  mode select: 1 = periodic, 0 = one-shot. Sampled at each terminal event.
- clr_expired  input  1  clears the sticky expired flag.
- out  output  WIDTH  current count value (registered).
- busy  output  1  high while in state RUN.
- tc  output  1  terminal-count pulse, exactly one cycle wide (registered).
- expired  output  1  sticky flag, set on every terminal event.

Behaviour:
- Reset is synchronous and active-low: reset is sampled low at a rising edge of clk.
- Reset values:
  - out = 0, busy = 0, tc = 0, expired = 0.
  - Prescaler count = 0, internal reload register = 0, state = IDLE.
- Reset overrides every other input, including mid-count and when coincident with load.
- There are two states: IDLE and RUN. busy = (state == RUN).
- tc defaults to 0 every cycle unless a terminal event occurs in that cycle.
- Load, in any state, has highest priority after reset. On an edge with load = 1:
  - reload register <= load_value, out <= load_value, prescaler <= 0.
  - If load_value != 0, state <= RUN.
  - If load_value == 0, the load is an immediate terminal event: tc <= 1, expired <= 1, state <= IDLE. This applies even when auto_reload = 1, so a zero period never free-runs.
  - No decrement happens on a load edge. A load in RUN discards the count in progress, and no tc is generated for the discarded count.
- RUN, load = 0, enable = 0: out and prescaler hold, and state is unchanged.
- RUN, load = 0, enable = 1:
  - If prescaler != PRESCALE-1: prescaler <= prescaler + 1.
  - Otherwise: prescaler <= 0 and a decrement step occurs.
- Decrement step with out > 1: out <= out - 1.
- Decrement step with out == 1 is a terminal event: tc <= 1 and expired <= 1.
  - auto_reload = 1: out <= reload register, state stays RUN, and counting continues without a dead cycle.
  - auto_reload = 0: out <= 0 and state <= IDLE.
- out never underflows, and out == 0 in RUN is unreachable.
- IDLE with load = 0: out holds (0 after a one-shot completes), and enable is ignored.
- Latency and period:
  - With load at edge k and enable held high, the first decrement happens at edge k + PRESCALE.
  - tc and out == 0 (one-shot) appear together at edge k + N*PRESCALE, where N = load_value.
  - In auto-reload mode, tc repeats every N*PRESCALE enabled cycles.
- expired clears at an edge with clr_expired = 1. If a terminal event and clr_expired occur on the same edge, set wins and expired = 1.
- Arithmetic is unsigned WIDTH-bit. The maximum period is 8191 * PRESCALE enabled cycles.

Test Plan:
- Reset: drive reset = 0 for 2 cycles with load = 1 and load_value = 100. Required: out = 0, busy = 0, tc = 0, expired = 0 throughout. Release reset; all outputs stay 0 with no load.
- One-shot, PRESCALE = 1: load 5 at edge k, enable = 1. Required:
  - out = 5,4,3,2,1,0 at edges k..k+5.
  - tc = 1 only at edge k+5.
  - busy falls at k+5 and expired = 1.
  - Then pulse clr_expired; expired = 0.
- Auto-reload with gaps: auto_reload = 1, load 3, enable toggling 1,0,1,1,0,1,... Required:
  - out holds on enable = 0 cycles.
  - tc pulses each time out goes 1 -> 3 (out never shows 0).
  - Exactly one tc per 3 enabled cycles; busy stays 1.
- Prescaler, PRESCALE = 4: load 2, enable = 1. Required:
  - out = 2 for 4 edges, then 1 for 4 edges.
  - tc and out = 0 at edge k+8.
- Load collisions:
  - Load 10 while out = 1 on a decrement edge. Required: out = 10, no tc, busy = 1.
  - Load 0 during RUN. Required: tc one cycle, out = 0, state IDLE.
  - Terminal event coincident with clr_expired. Required: expired = 1.
- Reset mid-count: load 8191, run 100 cycles, then assert reset for 1 cycle. Required: out = 0, busy = 0, tc = 0 next edge, and no stale count resumes afterward.
